// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: default data width,
//   instruction field positions used by decode, and the {pc, ins} entry
//   layout carried through the fetch queue (default widths).
package fetch_pkg;

    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 32;
    localparam int FETCH_PC_W   = $clog2(FETCH_DEPTH);

    // Instruction field positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 25;
    localparam int DST_HI    = 24;
    localparam int DST_LO    = 20;
    localparam int SRC1_HI   = 19;
    localparam int SRC1_LO   = 15;
    localparam int SRC2_HI   = 14;
    localparam int SRC2_LO   = 10;
    localparam int CONST_HI  = 9;
    localparam int CONST_LO  = 0;
    localparam int MOFF_HI   = 14;
    localparam int MOFF_LO   = 0;

    // Queue entry at default widths; pc occupies the upper bits.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_DATA_W-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   QDEPTH-entry synchronous FIFO of {pc, ins} entries.
//   Ports:
//     clk_i    clock (rising edge)
//     rst_i    asynchronous active-high reset (pointers and count)
//     push_i   enqueue din_i this cycle
//     pop_i    dequeue head this cycle
//     flush_i  discard all entries; overrides push/pop
//     din_i    entry to enqueue
//     head_o   entry at the read pointer (meaningful when count_o != 0)
//     count_o  number of occupied entries
//   Handshake: the caller only asserts push_i when not full or when popping
//   in the same cycle, and only asserts pop_i when count_o != 0.
module fetch_fifo #(
    parameter int PC_W   = 5,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [PC_W+DATA_W-1:0]     din_i,
    output logic [PC_W+DATA_W-1:0]     head_o,
    output logic [$clog2(QDEPTH):0]    count_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int EW = PC_W + DATA_W;

    logic [EW-1:0] store_q [QDEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since QDEPTH is a power of 2.
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_d = count_q + (AW+1)'(1);
            else if (pop_i && !push_i) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) store_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch stage: PC register, writable instruction memory and a
//   small queue of fetched {PC, instruction} pairs so decode can stall.
//   Ports:
//     clk        clock (rising edge)
//     reset      asynchronous active-high reset
//     jump       redirect: flush queue, PC <= jumpPC (wins over everything)
//     jumpPC     redirect target
//     imem_we    instruction-memory write enable
//     imem_waddr write address
//     imem_wdata write data
//     out_ready  decode accepts the head entry this cycle
//     ins_valid  head entry present
//     insReg     head instruction (0 when empty)
//     insPC      head PC (0 when empty)
//     q_count    occupied queue entries
//   Handshake: the head transfers on a cycle with ins_valid & out_ready & ~jump.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int QDEPTH = 2,
    localparam int PC_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       jump,
    input  logic [PC_W-1:0]            jumpPC,
    input  logic                       imem_we,
    input  logic [PC_W-1:0]            imem_waddr,
    input  logic [DATA_W-1:0]          imem_wdata,
    input  logic                       out_ready,
    output logic                       ins_valid,
    output logic [DATA_W-1:0]          insReg,
    output logic [PC_W-1:0]            insPC,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] ins;
    } entry_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              push, pop;
    entry_t            fetch_entry;
    entry_t            head;
    logic [CW-1:0]     count;

    // Combinational read returns pre-write data on a same-cycle write.
    assign fetch_entry.pc  = pc_q;
    assign fetch_entry.ins = mem_q[pc_q];

    assign ins_valid = (count != '0);
    assign pop       = ins_valid && out_ready && !jump;
    assign push      = !jump && ((count != QFULL) || pop);

    always_comb begin
        pc_d = pc_q;
        if (jump)      pc_d = jumpPC;
        else if (push) pc_d = pc_q + PC_W'(1);   // wraps modulo DEPTH
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (imem_we) mem_q[imem_waddr] <= imem_wdata;
    end

    fetch_fifo #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jump),
        .din_i   (fetch_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign insReg  = ins_valid ? head.ins : '0;
    assign insPC   = ins_valid ? head.pc  : '0;
    assign q_count = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage: holds the PC, reads a writable instruction memory, and buffers fetched {PC, instruction} pairs in a small queue so decode can stall without losing work. A jump redirect flushes the queue and reloads the PC. It sits between the instruction memory image and the decode stage, and replaces the fixed 32×32, non-stallable fetch.

## Interface
- DATA_W, 32, instruction width in bits.
- DEPTH, 32, instruction-memory entries; must be a power of 2.
- QDEPTH, 2, queue entries; must be a power of 2 and at least 2.
- PC_W, derived as log2(DEPTH); not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- jump  in  1  redirect request; 1 overrides the PC.
- jumpPC  in  PC_W  redirect target.
- imem_we  in  1  instruction-memory write enable.
- imem_waddr  in  PC_W  write address.
- imem_wdata  in  DATA_W  write data.
- out_ready  in  1  decode accepts the head entry this cycle.
- ins_valid  out  1  head entry present.
- insReg  out  DATA_W  head instruction; 0 when ins_valid=0.
- insPC  out  PC_W  PC of the head instruction; 0 when ins_valid=0.
- q_count  out  log2(QDEPTH)+1  number of occupied queue entries.

## Operation
- Reset values: PC=0, queue empty, read/write pointers 0, q_count=0, ins_valid=0, insReg=0, insPC=0. Memory contents are not reset.
- Memory: combinational read at the PC; synchronous write when imem_we=1. A same-cycle read of the address being written returns the old data.
- pop = ins_valid & out_ready & ~jump.
- push = ~jump & (q_count<QDEPTH | pop). A push enqueues {PC, mem[PC]} and sets PC <= PC+1 modulo DEPTH, so DEPTH-1 wraps to 0.
- When the queue is full and nothing is popped, the PC holds and no push occurs.
- When push and pop happen together, q_count is unchanged.
- On jump=1:
  - PC <= jumpPC.
  - All queue entries are discarded: q_count=0, pointers reset to 0.
  - No push and no pop. The head is discarded even if out_ready=1.
  - jump takes precedence over every other event.
- jump held for multiple cycles: the PC reloads every cycle and the queue stays empty.
- Queue pointers wrap modulo QDEPTH. Full is q_count==QDEPTH; empty is q_count==0.
- Asserting reset mid-stream immediately clears PC, queue and outputs, asynchronously.

## Timing
- Fill latency: first rising edge after reset deassertion pushes mem[0]. ins_valid=1, insPC=0 after that edge.
- Throughput: one instruction per cycle while out_ready=1. Steady state q_count=1.
- Redirect: jump sampled at edge N gives ins_valid=0 after N. mem[jumpPC] is valid after edge N+1, so the redirect bubble is 1 cycle.
- Backpressure: with out_ready=0, the queue fills to QDEPTH after QDEPTH edges and the PC then freezes.
- Release: one instruction leaves per cycle after out_ready rises. Refill proceeds in parallel.
- Outputs are a pure function of queue state: registered, with no combinational path from the inputs.
- Memory write at edge N is visible to a fetch in the cycle after N.

## Structure
- Package fetch_pkg:
  - DATA_W default.
  - Instruction field positions: opcode 31:25, dst 24:20, src1 19:15, src2 14:10, constant 9:0, M-type offset 14:0.
  - Packed typedef fetch_entry_t = {pc, ins}.
- Sub-module fetch_fifo: QDEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count and asynchronous reset. fetch_queue holds the PC, the memory and the push/pop/jump arbitration.

## Test plan
- Reset, preload mem[0..3]=0x11,0x22,0x33,0x44, out_ready=1 -> insPC 0,1,2,3 and insReg 0x11..0x44 on consecutive cycles, q_count=1.
- out_ready=0 for 5 cycles from reset (QDEPTH=2) -> q_count saturates at 2, head insPC=0. Raise out_ready -> PCs 0,1,2,3 follow with no gap or duplicate.
- Full queue, then jump=1 with jumpPC=22 and out_ready=1 -> next cycle ins_valid=0, q_count=0. Cycle after -> insPC=22, insReg=mem[22].
- Start from PC=30 (via jump) with DEPTH=32 -> insPC sequence 30,31,0,1.
- Assert reset asynchronously mid-stream between edges -> outputs 0 and q_count=0 immediately. After release, fetch restarts at PC 0.
- imem_we writes 0xABCD to address 5 in the same cycle the PC=5 fetch occurs -> entry 5 carries the old value. A later jump to 5 returns 0xABCD.
